// File: rtl/uart_rx_frame_ctrl.sv
// UART receiver control/data stage: frame FSM driving edge_bit_counter,
// mid-bit majority sampling, LSB-first deserialization, parity/stop checks.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            edge_count,
  input  logic [3:0]            bit_count,
  output logic                  counter_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [2:0]            samples;
  logic                  sampled_bit;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  prescale_ok;
  logic [4:0]            half;
  logic [4:0]            last;
  logic                  decide;
  logic                  majority;

  always_comb begin
    prescale_ok = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
    half        = Prescale[5:1];
    last        = 5'(Prescale - 6'd1);
    decide      = (edge_count == last);
    majority    = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                  (samples[1] & samples[2]);
  end

  // Three samples straddle mid-bit; the vote lands one edge later and holds until the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      samples     <= '0;
      sampled_bit <= 1'b0;
    end else if (state != IDLE) begin
      if (edge_count == half - 5'd1) samples[0] <= RX_IN;
      if (edge_count == half)        samples[1] <= RX_IN;
      if (edge_count == half + 5'd1) samples[2] <= RX_IN;
      if (edge_count == half + 5'd2) sampled_bit <= majority;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      counter_enable <= 1'b0;
      P_DATA         <= '0;
      data_valid     <= 1'b0;
      par_err        <= 1'b0;
      stp_err        <= 1'b0;
      shift_reg      <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      // An illegal ratio mid-frame discards the frame without touching the flags.
      if (state != IDLE && !prescale_ok) begin
        state          <= IDLE;
        counter_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!RX_IN && prescale_ok) begin
              state          <= START;
              counter_enable <= 1'b1;
            end
          end
          START: begin
            if (decide) begin
              if (!sampled_bit) begin
                par_err   <= 1'b0;
                stp_err   <= 1'b0;
                shift_reg <= '0;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                state     <= DATA;
              end else begin
                state          <= IDLE;
                counter_enable <= 1'b0;
              end
            end
          end
          DATA: begin
            if (decide) begin
              shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
              if (bit_count == LAST_DATA) state <= par_en_q ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (decide) begin
              par_err <= sampled_bit != (^shift_reg ^ par_typ_q);
              state   <= STOP;
            end
          end
          STOP: begin
            if (decide) begin
              stp_err <= ~sampled_bit;
              if (sampled_bit && !par_err) begin
                P_DATA     <= shift_reg;
                data_valid <= 1'b1;
              end
              state          <= IDLE;
              counter_enable <= 1'b0;
            end
          end
          default: begin
            state          <= IDLE;
            counter_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: stands in for edge_bit_counter, drives serial
// frames and compares against a per-frame behavioural model.
module tb_uart_rx_frame_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         RX_IN;
  logic [5:0]   Prescale;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [4:0]   edge_count;
  logic [3:0]   bit_count;
  logic         counter_enable;
  logic [W-1:0] P_DATA;
  logic         data_valid;
  logic         par_err;
  logic         stp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cycles = 0;

  logic [W-1:0] exp_pdata;
  bit           exp_par;
  bit           exp_stp;
  logic [W-1:0] vq[$];
  int           tq[$];

  uart_rx_frame_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .edge_count(edge_count), .bit_count(bit_count),
    .counter_enable(counter_enable), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter stand-in: held at zero while disabled, edge wraps at Prescale-1.
  always @(posedge clk) begin
    if (rst || !counter_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == 5'(Prescale - 6'd1)) begin
      edge_count <= '0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 5'd1;
    end
  end

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      vq.push_back(P_DATA);
      tq.push_back(cyc);
    end
    if (counter_enable === 1'b1) en_cycles++;
  end

  function automatic bit model_frame(input logic [W-1:0] data, input bit pen, input bit ptyp,
                                     input bit par_bit, input bit stop_bit);
    bit want;
    want    = bit'($countones(data) % 2) ^ ptyp;
    exp_par = pen && (par_bit != want);
    exp_stp = !stop_bit;
    if (!exp_par && !exp_stp) exp_pdata = data;
    return !exp_par && !exp_stp;
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] data, input bit par_bit, input bit stop_bit,
                            input int gbit, input int goff, output int start);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(data[i]);
    if (PAR_EN) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    start = cyc;
    for (int b = 0; b < bits.size(); b++) begin
      for (int o = 0; o < int'(Prescale); o++) begin
        RX_IN = bits[b] ^ ((b == gbit) && (o == goff));
        @(posedge clk);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({counter_enable, data_valid, par_err, stp_err} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=0000", {counter_enable, data_valid, par_err, stp_err});
    end
    checks++;
    if (P_DATA !== '0) begin
      failures++;
      $display("[TB] FAIL reset_pdata got=%h want=00", P_DATA);
    end
    rst = 1'b0;
    exp_pdata = '0; exp_par = 1'b0; exp_stp = 1'b0;
    idle(4);
    checks++;
    if (counter_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_enable got=%b want=0", counter_enable);
    end
  endtask

  task automatic test_basic();
    int st, n0;
    bit ev;
    Prescale = 6'd8; PAR_EN = 1'b0;
    n0 = vq.size();
    ev = model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, -1, 0, st);
    idle(4);
    checks++;
    if (vq.size() - n0 != int'(ev)) begin
      failures++;
      $display("[TB] FAIL basic_pulses got=%0d want=%0d", vq.size() - n0, ev);
    end
    if (vq.size() > n0) begin
      checks++;
      if (vq[vq.size()-1] !== 8'hA5) begin
        failures++;
        $display("[TB] FAIL basic_data got=%h want=a5", vq[vq.size()-1]);
      end
      checks++;
      if (tq[tq.size()-1] != st + 10 * 8 + 1) begin
        failures++;
        $display("[TB] FAIL basic_latency got=%0d want=%0d", tq[tq.size()-1], st + 81);
      end
    end
    checks++;
    if ({par_err, stp_err} !== {exp_par, exp_stp}) begin
      failures++;
      $display("[TB] FAIL basic_flags got=%b%b want=%b%b", par_err, stp_err, exp_par, exp_stp);
    end
  endtask

  task automatic test_parity();
    int st, n0;
    bit ev;
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n0 = vq.size();
      ev = model_frame(8'h3C, 1'b1, 1'b0, k[0], 1'b1);
      send_frame(8'h3C, k[0], 1'b1, -1, 0, st);
      idle(4);
      checks++;
      if (vq.size() - n0 != int'(ev)) begin
        failures++;
        $display("[TB] FAIL parity%0d_pulses got=%0d want=%0d", k, vq.size() - n0, ev);
      end
      checks++;
      if (P_DATA !== exp_pdata || par_err !== exp_par || stp_err !== exp_stp) begin
        failures++;
        $display("[TB] FAIL parity%0d_out got=%h/%b/%b want=%h/%b/%b", k, P_DATA, par_err,
                 stp_err, exp_pdata, exp_par, exp_stp);
      end
    end
  endtask

  task automatic test_runt();
    int n0;
    Prescale = 6'd16; PAR_EN = 1'b0;
    n0 = vq.size();
    RX_IN = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    idle(5);
    checks++;
    if (counter_enable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL runt_active got=%b want=1", counter_enable);
    end
    idle(20);
    checks++;
    if (counter_enable !== 1'b0 || vq.size() != n0) begin
      failures++;
      $display("[TB] FAIL runt_idle got=en%b/pulses%0d want=en0/pulses0", counter_enable, vq.size() - n0);
    end
    checks++;
    if ({par_err, stp_err} !== {exp_par, exp_stp}) begin
      failures++;
      $display("[TB] FAIL runt_flags got=%b%b want=%b%b", par_err, stp_err, exp_par, exp_stp);
    end
  endtask

  task automatic test_abort();
    int n0;
    Prescale = 6'd16; PAR_EN = 1'b0;
    n0 = vq.size();
    RX_IN = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    idle(30);
    exp_par = 1'b0; exp_stp = 1'b0;
    checks++;
    if (counter_enable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_active got=%b want=1", counter_enable);
    end
    Prescale = 6'd12;
    idle(2);
    checks++;
    if (counter_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_enable got=%b want=0", counter_enable);
    end
    Prescale = 6'd16;
    idle(40);
    checks++;
    if (vq.size() != n0 || {par_err, stp_err} !== {exp_par, exp_stp}) begin
      failures++;
      $display("[TB] FAIL abort_after got=pulses%0d/%b%b want=pulses0/%b%b", vq.size() - n0,
               par_err, stp_err, exp_par, exp_stp);
    end
  endtask

  task automatic test_stop();
    int st, n0;
    bit ev;
    Prescale = 6'd32; PAR_EN = 1'b0;
    n0 = vq.size();
    ev = model_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, -1, 0, st);
    idle(4);
    checks++;
    if (vq.size() - n0 != int'(ev) || stp_err !== exp_stp || P_DATA !== exp_pdata) begin
      failures++;
      $display("[TB] FAIL stop_err got=pulses%0d/stp%b/%h want=pulses%0d/stp%b/%h", vq.size() - n0,
               stp_err, P_DATA, ev, exp_stp, exp_pdata);
    end
    n0 = vq.size();
    ev = model_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      send_frame(8'h5A, 1'b0, 1'b1, -1, 0, st);
      begin
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (stp_err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stop_clear_at_start got=%b want=0", stp_err);
        end
      end
    join
    idle(4);
    checks++;
    if (vq.size() - n0 != int'(ev) || P_DATA !== 8'h5A || stp_err !== exp_stp) begin
      failures++;
      $display("[TB] FAIL stop_recover got=pulses%0d/%h/stp%b want=pulses%0d/5a/stp%b", vq.size() - n0,
               P_DATA, stp_err, ev, exp_stp);
    end
  endtask

  task automatic test_glitch();
    int st, n0;
    bit ev;
    Prescale = 6'd16; PAR_EN = 1'b0;
    n0 = vq.size();
    ev = model_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    // Line offset H+1 of frame bit 3 is the cycle captured by the edge_count==H sample.
    send_frame(8'h96, 1'b0, 1'b1, 3, 9, st);
    idle(4);
    checks++;
    if (vq.size() - n0 != int'(ev) || P_DATA !== exp_pdata) begin
      failures++;
      $display("[TB] FAIL glitch got=pulses%0d/%h want=pulses%0d/%h", vq.size() - n0, P_DATA, ev, exp_pdata);
    end
  endtask

  task automatic test_back_to_back();
    int st1, st2, n0;
    bit ev;
    Prescale = 6'd8; PAR_EN = 1'b0;
    n0 = vq.size();
    ev = model_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    ev = model_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1, -1, 0, st1);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 0, st2);
    idle(5);
    checks++;
    if (vq.size() - n0 != 2) begin
      failures++;
      $display("[TB] FAIL b2b_pulses got=%0d want=2", vq.size() - n0);
    end else begin
      checks++;
      if (vq[n0] !== 8'h01 || vq[n0+1] !== 8'hFF) begin
        failures++;
        $display("[TB] FAIL b2b_data got=%h,%h want=01,ff", vq[n0], vq[n0+1]);
      end
      checks++;
      if (tq[n0] != st1 + 81 || tq[n0+1] != st2 + 82) begin
        failures++;
        $display("[TB] FAIL b2b_timing got=%0d,%0d want=%0d,%0d", tq[n0], tq[n0+1], st1 + 81, st2 + 82);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    Prescale = 6'd8; PAR_EN = 1'b0;
    n0 = vq.size();
    RX_IN = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    RX_IN = 1'b1;
    for (int i = 0; i < 100 && bit_count !== 4'd4; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bit_count !== 4'd4) begin
      failures++;
      $display("[TB] FAIL rst_reach_bit4 got=%0d want=4", bit_count);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_pdata = '0; exp_par = 1'b0; exp_stp = 1'b0;
    checks++;
    if ({counter_enable, data_valid, par_err, stp_err} !== 4'b0000 || P_DATA !== exp_pdata) begin
      failures++;
      $display("[TB] FAIL rst_midframe got=%b/%h want=0000/00",
               {counter_enable, data_valid, par_err, stp_err}, P_DATA);
    end
    rst = 1'b0;
    idle(30);
    checks++;
    if (vq.size() != n0 || counter_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_discard got=pulses%0d/en%b want=pulses0/en0", vq.size() - n0, counter_enable);
    end
  endtask

  task automatic test_illegal_prescale();
    int n0, e0;
    Prescale = 6'd12;
    n0 = vq.size();
    e0 = en_cycles;
    for (int i = 0; i < 200; i++) begin
      RX_IN = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    idle(2);
    checks++;
    if (en_cycles != e0 || vq.size() != n0) begin
      failures++;
      $display("[TB] FAIL illegal_prescale got=en%0d/pulses%0d want=0/0", en_cycles - e0, vq.size() - n0);
    end
    Prescale = 6'd16;
  endtask

  task automatic test_random();
    int st, n0, nbits;
    bit ev, pbit, sbit;
    logic [W-1:0] d;
    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 2))
        0: Prescale = 6'd8;
        1: Prescale = 6'd16;
        default: Prescale = 6'd32;
      endcase
      PAR_EN  = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      d       = W'($urandom);
      pbit    = 1'($urandom_range(0, 1));
      sbit    = ($urandom_range(0, 4) != 0);
      nbits   = 2 + W + int'(PAR_EN);
      n0      = vq.size();
      ev      = model_frame(d, PAR_EN, PAR_TYP, pbit, sbit);
      send_frame(d, pbit, sbit, -1, 0, st);
      idle($urandom_range(3, 6));
      checks++;
      if (vq.size() - n0 != int'(ev)) begin
        failures++;
        $display("[TB] FAIL rand%0d_pulses got=%0d want=%0d", f, vq.size() - n0, ev);
      end else if (ev) begin
        checks++;
        if (tq[tq.size()-1] != st + nbits * int'(Prescale) + 1) begin
          failures++;
          $display("[TB] FAIL rand%0d_latency got=%0d want=%0d", f, tq[tq.size()-1],
                   st + nbits * int'(Prescale) + 1);
        end
      end
      checks++;
      if (P_DATA !== exp_pdata || par_err !== exp_par || stp_err !== exp_stp) begin
        failures++;
        $display("[TB] FAIL rand%0d_out got=%h/%b/%b want=%h/%b/%b", f, P_DATA, par_err, stp_err,
                 exp_pdata, exp_par, exp_stp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_runt();
    test_abort();
    test_stop();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_illegal_prescale();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
